// File: rtl/vga_timing_gen.sv
// VGA raster timing generator: pixel/line counters, active-video flag, sync strobes.
// Latency: 1 clk from an enabled cycle to the registered position it describes.
// Backpressure: none; pix_en gates advancement and all outputs hold while it is low.
module vga_timing_gen #(
    parameter int H_ACTIVE = 640,
    parameter int H_FP     = 16,
    parameter int H_SYNC   = 96,
    parameter int H_BP     = 48,
    parameter int V_ACTIVE = 480,
    parameter int V_FP     = 10,
    parameter int V_SYNC   = 2,
    parameter int V_BP     = 33,
    parameter int SYNC_POL = 0
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       pix_en,
    output logic [9:0] hcount_out,
    output logic [9:0] vcount_out,
    output logic       vga_active_out,
    output logic       hsync_out,
    output logic       vsync_out,
    output logic       line_start_out,
    output logic       frame_start_out
);

    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

    // Counters are 10 bits wide, so neither raster dimension may exceed 1024.
    if (H_TOTAL > 1024 || V_TOTAL > 1024) begin : g_total_check
        $error("vga_timing_gen: H_TOTAL/V_TOTAL must not exceed 1024");
    end

    localparam logic [9:0] H_LAST   = 10'(H_TOTAL - 1);
    localparam logic [9:0] V_LAST   = 10'(V_TOTAL - 1);
    localparam logic [9:0] H_VIS    = 10'(H_ACTIVE);
    localparam logic [9:0] V_VIS    = 10'(V_ACTIVE);
    localparam logic [9:0] HS_FIRST = 10'(H_ACTIVE + H_FP);
    localparam logic [9:0] HS_LAST  = 10'(H_ACTIVE + H_FP + H_SYNC - 1);
    localparam logic [9:0] VS_FIRST = 10'(V_ACTIVE + V_FP);
    localparam logic [9:0] VS_LAST  = 10'(V_ACTIVE + V_FP + V_SYNC - 1);
    localparam logic       SYNC_ON  = (SYNC_POL != 0);

    // Set by the first enabled cycle after reset; until then the next position is (0,0)
    // rather than (1,0), so the first visible pixel is the origin.
    logic       started;
    logic [9:0] h_nxt;
    logic [9:0] v_nxt;

    // Next raster position: origin before the first advance, otherwise step with wrap.
    always_comb begin
        h_nxt = 10'd0;
        v_nxt = 10'd0;
        if (started) begin
            if (hcount_out == H_LAST) begin
                h_nxt = 10'd0;
                v_nxt = (vcount_out == V_LAST) ? 10'd0 : vcount_out + 10'd1;
            end else begin
                h_nxt = hcount_out + 10'd1;
                v_nxt = vcount_out;
            end
        end
    end

    // All outputs are decoded from the next position and registered together, so every
    // output always describes the same (hcount, vcount) pair.
    always_ff @(posedge clk) begin
        if (rst) begin
            started         <= 1'b0;
            hcount_out      <= 10'd0;
            vcount_out      <= 10'd0;
            vga_active_out  <= 1'b0;
            hsync_out       <= ~SYNC_ON;
            vsync_out       <= ~SYNC_ON;
            line_start_out  <= 1'b0;
            frame_start_out <= 1'b0;
        end else if (pix_en) begin
            started         <= 1'b1;
            hcount_out      <= h_nxt;
            vcount_out      <= v_nxt;
            vga_active_out  <= (h_nxt < H_VIS) && (v_nxt < V_VIS);
            hsync_out       <= (h_nxt >= HS_FIRST && h_nxt <= HS_LAST) ? SYNC_ON : ~SYNC_ON;
            vsync_out       <= (v_nxt >= VS_FIRST && v_nxt <= VS_LAST) ? SYNC_ON : ~SYNC_ON;
            line_start_out  <= (h_nxt == 10'd0);
            frame_start_out <= (h_nxt == 10'd0) && (v_nxt == 10'd0);
        end else begin
            // Position holds; start strobes are single-clk regardless of enable gaps.
            line_start_out  <= 1'b0;
            frame_start_out <= 1'b0;
        end
    end

endmodule

// File: tb/tb_vga_timing_gen.sv
// Testbench for vga_timing_gen: default 640x480 instance and a small SYNC_POL=1 instance.
// Expected records are queued when stimulus is driven and compared 1 ns after the edge.
// A linear pixel-index model supplies expectations outside the fixed startup table.
module tb_vga_timing_gen;

    typedef struct packed {
        logic [9:0] h;
        logic [9:0] v;
        logic       act;
        logic       hs;
        logic       vs;
        logic       ls;
        logic       fs;
    } exp_t;

    typedef struct {
        bit   r;
        bit   e;
        exp_t x;
    } vec_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst_a = 1'b1, en_a = 1'b0, rst_b = 1'b1, en_b = 1'b0;
    logic [9:0] a_h, a_v, b_h, b_v;
    logic       a_act, a_hs, a_vs, a_ls, a_fs;
    logic       b_act, b_hs, b_vs, b_ls, b_fs;

    vga_timing_gen dut_a (
        .clk(clk), .rst(rst_a), .pix_en(en_a),
        .hcount_out(a_h), .vcount_out(a_v), .vga_active_out(a_act),
        .hsync_out(a_hs), .vsync_out(a_vs),
        .line_start_out(a_ls), .frame_start_out(a_fs)
    );

    vga_timing_gen #(
        .H_ACTIVE(8), .H_FP(2), .H_SYNC(2), .H_BP(2),
        .V_ACTIVE(4), .V_FP(1), .V_SYNC(1), .V_BP(1), .SYNC_POL(1)
    ) dut_b (
        .clk(clk), .rst(rst_b), .pix_en(en_b),
        .hcount_out(b_h), .vcount_out(b_v), .vga_active_out(b_act),
        .hsync_out(b_hs), .vsync_out(b_vs),
        .line_start_out(b_ls), .frame_start_out(b_fs)
    );

    // Geometry of the two instances: index 0 = default, index 1 = small.
    int g_ha[2] = '{640, 8};
    int g_hf[2] = '{16, 2};
    int g_hs[2] = '{96, 2};
    int g_hb[2] = '{48, 2};
    int g_va[2] = '{480, 4};
    int g_vf[2] = '{10, 1};
    int g_vs[2] = '{2, 1};
    int g_vb[2] = '{33, 1};
    bit g_pol[2] = '{1'b0, 1'b1};

    bit   m_started[2];
    int   m_p[2];
    exp_t m_last[2];

    exp_t qa[$];
    exp_t qb[$];

    int    checks = 0;
    int    errors = 0;
    string phase  = "init";

    // Reference model: position kept as a linear pixel index within the frame.
    function automatic exp_t model_step(int i, bit r, bit e);
        int ht, vt, h, v, hs0, vs0;
        bit pol;
        exp_t x;
        ht  = g_ha[i] + g_hf[i] + g_hs[i] + g_hb[i];
        vt  = g_va[i] + g_vf[i] + g_vs[i] + g_vb[i];
        pol = g_pol[i];
        if (r) begin
            m_started[i] = 1'b0;
            m_p[i]       = 0;
            x            = '{10'd0, 10'd0, 1'b0, ~pol, ~pol, 1'b0, 1'b0};
        end else if (e) begin
            if (!m_started[i]) begin
                m_started[i] = 1'b1;
                m_p[i]       = 0;
            end else begin
                m_p[i] = (m_p[i] + 1) % (ht * vt);
            end
            h   = m_p[i] % ht;
            v   = m_p[i] / ht;
            hs0 = g_ha[i] + g_hf[i];
            vs0 = g_va[i] + g_vf[i];
            x.h   = 10'(h);
            x.v   = 10'(v);
            x.act = (h < g_ha[i]) && (v < g_va[i]);
            x.hs  = (h >= hs0 && h < hs0 + g_hs[i]) ? pol : ~pol;
            x.vs  = (v >= vs0 && v < vs0 + g_vs[i]) ? pol : ~pol;
            x.ls  = (h == 0);
            x.fs  = (m_p[i] == 0);
        end else begin
            x    = m_last[i];
            x.ls = 1'b0;
            x.fs = 1'b0;
        end
        m_last[i] = x;
        return x;
    endfunction

    task automatic check_rec(input string nm, input exp_t want, input exp_t got);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s/%s: got h=%0d v=%0d act=%b hs=%b vs=%b ls=%b fs=%b, want h=%0d v=%0d act=%b hs=%b vs=%b ls=%b fs=%b",
                     phase, nm, got.h, got.v, got.act, got.hs, got.vs, got.ls, got.fs,
                     want.h, want.v, want.act, want.hs, want.vs, want.ls, want.fs);
        end
    endtask

    task automatic check_int(input string nm, input int got, input int want);
        checks++;
        if (got != want) begin
            errors++;
            $display("FAIL %s/%s: got %0d, want %0d", phase, nm, got, want);
        end
    endtask

    // One clock: drive inputs at negedge, queue expectations, compare after the edge.
    // When use_tab is set, the table record replaces the model expectation for dut_a.
    task automatic cycle(input bit ra, input bit ea, input bit rb, input bit eb,
                         input bit use_tab, input exp_t tab_x);
        exp_t xa, xb, wa, wb, ga, gb;
        @(negedge clk);
        rst_a = ra; en_a = ea; rst_b = rb; en_b = eb;
        xa = model_step(0, ra, ea);
        xb = model_step(1, rb, eb);
        qa.push_back(use_tab ? tab_x : xa);
        qb.push_back(xb);
        @(posedge clk);
        #1;
        ga = '{a_h, a_v, a_act, a_hs, a_vs, a_ls, a_fs};
        gb = '{b_h, b_v, b_act, b_hs, b_vs, b_ls, b_fs};
        wa = qa.pop_front();
        wb = qb.pop_front();
        check_rec("a", wa, ga);
        check_rec("b", wb, gb);
    endtask

    initial begin
        vec_t tab[7];
        exp_t none;
        int   n_act, n_hs, n_vs, n_ls, n_fs;

        none = '0;
        // Startup of the default instance: 3 reset clks (rst beats pix_en), then origin.
        tab[0] = '{1'b1, 1'b0, '{10'd0, 10'd0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0}};
        tab[1] = '{1'b1, 1'b1, '{10'd0, 10'd0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0}};
        tab[2] = '{1'b1, 1'b1, '{10'd0, 10'd0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0}};
        tab[3] = '{1'b0, 1'b1, '{10'd0, 10'd0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1}};
        tab[4] = '{1'b0, 1'b0, '{10'd0, 10'd0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0}};
        tab[5] = '{1'b0, 1'b1, '{10'd1, 10'd0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0}};
        tab[6] = '{1'b0, 1'b1, '{10'd2, 10'd0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0}};

        phase = "startup";
        for (int i = 0; i < 7; i++) cycle(tab[i].r, tab[i].e, 1'b1, 1'b0, 1'b1, tab[i].x);

        // Rest of line 0 and the start of line 1 (positions 3..799, then (0,1)..(2,1)).
        phase = "line0";
        n_act = 0; n_hs = 0; n_ls = 0; n_fs = 0;
        for (int k = 0; k < 800; k++) begin
            cycle(1'b0, 1'b1, 1'b1, 1'b0, 1'b0, none);
            if (a_v == 10'd0 && a_act) n_act++;
            if (a_v == 10'd0 && !a_hs) n_hs++;
            if (a_ls) n_ls++;
            if (a_fs) n_fs++;
        end
        check_int("active_px_3_to_639", n_act, 637);
        check_int("hsync_low_px", n_hs, 96);
        check_int("line_starts", n_ls, 1);
        check_int("frame_starts", n_fs, 0);
        check_int("end_pos_h", int'(a_h), 2);
        check_int("end_pos_v", int'(a_v), 1);

        // Enable every 4th clk across the (0,2) line boundary; strobe must last 1 clk.
        phase = "gated";
        n_ls = 0;
        for (int k = 0; k < 3240; k++) begin
            cycle(1'b0, (k % 4) == 3, 1'b1, 1'b0, 1'b0, none);
            if (a_ls) n_ls++;
        end
        check_int("gated_line_start_clks", n_ls, 1);

        // Reset mid-line, idle after release, then restart at the origin.
        phase = "reset_mid";
        cycle(1'b1, 1'b1, 1'b1, 1'b0, 1'b0, none);
        cycle(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, none);
        cycle(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, none);
        check_int("idle_after_rst_active", int'(a_act), 0);
        cycle(1'b0, 1'b1, 1'b1, 1'b0, 1'b0, none);
        check_int("restart_frame_start", int'(a_fs), 1);
        cycle(1'b0, 1'b1, 1'b1, 1'b0, 1'b0, none);

        // Small instance: two full frames plus the return to the origin.
        phase = "small_frames";
        cycle(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, none);
        cycle(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, none);
        n_act = 0; n_hs = 0; n_vs = 0; n_fs = 0;
        for (int k = 0; k < 197; k++) begin
            cycle(1'b1, 1'b0, 1'b0, 1'b1, 1'b0, none);
            if (k < 98) begin
                if (b_act) n_act++;
                if (b_hs) n_hs++;
                if (b_vs) n_vs++;
                if (b_hs && (b_h < 10'd10 || b_h > 10'd11)) n_hs += 1000;
                if (b_vs && b_v != 10'd5) n_vs += 1000;
            end
            if (b_fs) n_fs++;
        end
        check_int("small_active_px", n_act, 32);
        check_int("small_hsync_px", n_hs, 14);
        check_int("small_vsync_px", n_vs, 14);
        check_int("small_frame_starts", n_fs, 3);

        // Small instance: enable every 3rd clk with a reset dropped in mid-frame.
        phase = "small_gated_reset";
        for (int k = 0; k < 150; k++) begin
            cycle(1'b1, 1'b0, (k >= 100 && k < 103), (k % 3) == 0, 1'b0, none);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/vga_timing_gen.md
Name: vga_timing_gen

Overview:
Generates VGA raster timing: the horizontal and vertical pixel counters, the active-video flag, and the hsync/vsync strobes. Downstream pixel generators consume hcount/vcount/active; the sync outputs go straight to the connector pins. It is the producer side of the hcount/vcount/active interface. It advances one pixel per clk cycle in which pix_en is high, so it runs either on a 25.175 MHz pixel clock (pix_en tied high) or on a faster system clock with a divided enable.

Parameters:
H_ACTIVE, 640, visible pixels per line
H_FP, 16, horizontal front porch (pixels)
H_SYNC, 96, hsync pulse width (pixels)
H_BP, 48, horizontal back porch (pixels)
V_ACTIVE, 480, visible lines per frame
V_FP, 10, vertical front porch (lines)
V_SYNC, 2, vsync pulse width (lines)
V_BP, 33, vertical back porch (lines)
SYNC_POL, 0, sync asserted level (0 = active-low, 1 = active-high)

Ports:
clk  input  1  system/pixel clock
rst  input  1  synchronous, active-high reset
pix_en  input  1  pixel advance enable
hcount_out  output  10  current pixel column, 0..H_TOTAL-1
vcount_out  output  10  current line, 0..V_TOTAL-1
vga_active_out  output  1  high when the current pixel is visible
hsync_out  output  1  horizontal sync, polarity per SYNC_POL
vsync_out  output  1  vertical sync, polarity per SYNC_POL
line_start_out  output  1  one-clk pulse when the position enters hcount=0
frame_start_out  output  1  one-clk pulse when the position enters (0,0)

Behaviour:
- One clock domain. Reset is synchronous and active-high on rst; clk and rst are the only clock and reset.
- Totals: H_TOTAL = H_ACTIVE+H_FP+H_SYNC+H_BP (default 800); V_TOTAL = V_ACTIVE+V_FP+V_SYNC+V_BP (default 525). Both totals must be ≤ 1024. This is checked by an elaboration-time assertion.
- All outputs are registered, with no combinational path from any input to any output.
- In every cycle, all outputs describe the same position (hcount_out, vcount_out).
- Reset values, held while rst=1:
  - hcount_out=0, vcount_out=0, vga_active_out=0
  - hsync_out and vsync_out deasserted (= ~SYNC_POL)
  - line_start_out=0, frame_start_out=0
  - internal "started" flag cleared
- First pix_en=1 cycle after reset releases:
  - outputs present position (0,0) with vga_active_out=1
  - line_start_out=1 and frame_start_out=1 for that single clk
  - started flag set
- Each subsequent pix_en=1 cycle advances the position:
  - hcount increments.
  - At H_TOTAL-1, hcount wraps to 0 and vcount increments.
  - At (H_TOTAL-1, V_TOTAL-1), both wrap to 0.
- pix_en=0: every output holds its value, except that line_start_out and frame_start_out return to 0 after one clk. The pulses are exactly one clk wide regardless of how long pix_en stays low.
- vga_active_out = (hcount < H_ACTIVE) && (vcount < V_ACTIVE).
- hsync_out = SYNC_POL when H_ACTIVE+H_FP ≤ hcount ≤ H_ACTIVE+H_FP+H_SYNC-1 (default 656..751), else ~SYNC_POL.
- vsync_out = SYNC_POL when V_ACTIVE+V_FP ≤ vcount ≤ V_ACTIVE+V_FP+V_SYNC-1 (default 490..491), for every hcount of those lines; else ~SYNC_POL.
- line_start_out pulses on each transition into hcount=0. frame_start_out pulses only on transitions into (0,0).
- rst asserted mid-frame or mid-line:
  - next edge forces the reset values
  - the sequence restarts at (0,0) on the first pix_en after release
  - no partial pulse is produced
- rst and pix_en high in the same cycle: rst wins.
- Count arithmetic is unsigned 10-bit; the wrap compare is an equality test against TOTAL-1. Counters never pass TOTAL-1.

Test Plan:
- rst for 3 clks, then pix_en=1 constantly → first clk: (0,0), active=1, line_start=1, frame_start=1. Next clk: (1,0), both pulses 0.
- Line 0 with pix_en=1 →
  - active=1 for hcount 0..639, 0 from 640
  - hsync_out=0 exactly at hcount 656..751
  - after 799: (0,1), line_start=1, frame_start=0
- Full frame (420000 pix_en cycles) →
  - vsync_out=0 on lines 490..491 only
  - active=0 on lines 480..524
  - (799,524) is followed by (0,0) with frame_start=1
  - exactly one frame_start per 420000 advances
- pix_en asserted every 4th clk →
  - outputs change only on enabled cycles, each advancing by one pixel
  - line_start/frame_start last 1 clk, not 4
- rst pulsed at (300,200) → outputs forced to reset values. First pix_en after release gives (0,0) with frame_start=1.
- SYNC_POL=1, small geometry (H 8/2/2/2, V 4/1/1/1) → hsync=1 at hcount 10..11, vsync=1 at vcount 5. Totals are 14 and 7; a full frame wraps after 98 advances.
